// File: rtl/trdb_grant_gen_if.sv
// ---------------------------------------------------------------------------
// trdb_grant_gen_if
//   Bundles the producer-facing packet-word handshake and the capture-FIFO
//   read port of trdb_grant_gen.
//
//   Handshake semantics (both directions):
//     - A producer word moves on channel c in a cycle where valid_i[c] and
//       grant_o[c] are both 1 at the rising edge. valid_i must not depend
//       on grant_o.
//     - A FIFO word is consumed in a cycle where word_valid_o and
//       word_ready_i are both 1 at the rising edge. word_o/word_chan_o are
//       stable while word_valid_o is 1 and no pop happens.
//
//   Signals:
//     valid_i      producer -> gen   per-channel word valid
//     data_i       producer -> gen   per-channel words, channel c at
//                                    [c*DataWidth +: DataWidth]
//     grant_o      gen -> producer   per-channel grant, one-hot or zero
//     word_valid_o gen -> consumer   FIFO not empty
//     word_o       gen -> consumer   FIFO head word
//     word_chan_o  gen -> consumer   FIFO head channel id
//     word_ready_i consumer -> gen   pop request
//   Modports: master = producer/consumer side, slave = trdb_grant_gen.
// ---------------------------------------------------------------------------
interface trdb_grant_gen_if #(
    parameter int NumChannels = 1,
    parameter int DataWidth   = 32,
    parameter int ChanW       = (NumChannels > 1) ? $clog2(NumChannels) : 1
);
    logic [NumChannels-1:0]           valid_i;
    logic [NumChannels*DataWidth-1:0] data_i;
    logic [NumChannels-1:0]           grant_o;
    logic                             word_valid_o;
    logic [DataWidth-1:0]             word_o;
    logic [ChanW-1:0]                 word_chan_o;
    logic                             word_ready_i;

    modport master (
        output valid_i, data_i, word_ready_i,
        input  grant_o, word_valid_o, word_o, word_chan_o
    );

    modport slave (
        input  valid_i, data_i, word_ready_i,
        output grant_o, word_valid_o, word_o, word_chan_o
    );
endinterface

// File: rtl/trdb_grant_gen.sv
// ---------------------------------------------------------------------------
// trdb_grant_gen
//   Grant generator and capture sink for trace packet words. A registered
//   grant enable is derived from the selected mode (always / LFSR random /
//   periodic / hold-delay); the enable is steered round-robin to one valid
//   channel, and every transferred word is stored with its channel id in a
//   small FIFO.
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     enable_i     0 forces grants low and clears the mode counters
//     mode_i       0 always, 1 random, 2 periodic, 3 hold-delay
//     prob_i       random-mode threshold against lfsr_q[7:0]
//     period_i     periodic interval / hold-delay length
//     bus          producer handshake and FIFO read port (slave modport)
//     fifo_full_o  FIFO holds FifoDepth entries
//     stall_cnt_o  saturating count of cycles with valid but no transfer
// ---------------------------------------------------------------------------
module trdb_grant_gen #(
    parameter int          NumChannels = 1,
    parameter int          DataWidth   = 32,
    parameter int          FifoDepth   = 4,
    parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic [1:0]           mode_i,
    input  logic [7:0]           prob_i,
    input  logic [7:0]           period_i,
    trdb_grant_gen_if.slave      bus,
    output logic                 fifo_full_o,
    output logic [15:0]          stall_cnt_o
);
    localparam int ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int AddrW = $clog2(FifoDepth);
    localparam int CntW  = AddrW + 1;

    logic [15:0]      lfsr_q, lfsr_d;
    logic             grant_en_q, grant_en_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       wait_q, wait_d;
    logic [ChanW-1:0] rr_ptr_q, rr_ptr_d;
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [15:0]      stall_q, stall_d;

    logic [DataWidth-1:0] mem_data [FifoDepth];
    logic [ChanW-1:0]     mem_chan [FifoDepth];

    logic             any_valid;
    logic             found;
    logic [ChanW-1:0] sel;
    logic [ChanW:0]   idx;   // one bit wider so rr_ptr_q + i fits before wrap
    logic             push;
    logic             pop;

    assign any_valid   = |bus.valid_i;
    assign fifo_full_o = (count_q == CntW'(FifoDepth));

    // Round-robin search: first valid channel at or above rr_ptr_q, wrapping.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NumChannels; i++) begin
            idx = {1'b0, rr_ptr_q} + (ChanW+1)'(i);
            if (idx >= (ChanW+1)'(NumChannels)) begin
                idx = idx - (ChanW+1)'(NumChannels);
            end
            if (!found && bus.valid_i[idx[ChanW-1:0]]) begin
                sel   = idx[ChanW-1:0];
                found = 1'b1;
            end
        end
    end

    // Full suppresses the grant even when a pop is pending, which keeps
    // word_ready_i out of the grant path.
    always_comb begin
        bus.grant_o = '0;
        if (grant_en_q && !fifo_full_o && found) begin
            bus.grant_o[sel] = 1'b1;
        end
    end

    assign push = |(bus.valid_i & bus.grant_o);
    assign pop  = (count_q != '0) && bus.word_ready_i;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        cnt_d = '0;
        if (enable_i && (cnt_q < period_i)) begin
            cnt_d = cnt_q + 8'd1;
        end

        wait_d = '0;
        if (enable_i && any_valid && !push) begin
            wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        end

        // Hold-delay uses the updated wait count so period_i idle cycles
        // separate consecutive grants (period_i=2 grants on the 3rd cycle).
        grant_en_d = 1'b0;
        if (enable_i) begin
            case (mode_i)
                2'd0:    grant_en_d = 1'b1;
                2'd1:    grant_en_d = (lfsr_q[7:0] < prob_i);
                2'd2:    grant_en_d = (cnt_q == period_i);
                default: grant_en_d = (wait_d >= period_i);
            endcase
        end

        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (sel == ChanW'(NumChannels - 1)) ? '0 : sel + ChanW'(1);
        end

        stall_d = stall_q;
        if (any_valid && !push && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end

        wr_ptr_d = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q     <= LfsrSeed;
            grant_en_q <= 1'b0;
            cnt_q      <= '0;
            wait_q     <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            grant_en_q <= grant_en_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= bus.data_i[sel*DataWidth +: DataWidth];
            mem_chan[wr_ptr_q] <= sel;
        end
    end

    assign bus.word_valid_o = (count_q != '0);
    assign bus.word_o       = mem_data[rd_ptr_q];
    assign bus.word_chan_o  = mem_chan[rd_ptr_q];
    assign stall_cnt_o      = stall_q;

endmodule

// File: tb/tb_trdb_grant_gen.sv
module tb_trdb_grant_gen;
  localparam int          NCH   = 3;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  prob;
  logic [7:0]  period;
  logic        fifo_full;
  logic [15:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];

  trdb_grant_gen_if #(.NumChannels(NCH), .DataWidth(DW)) bus ();

  trdb_grant_gen #(
    .NumChannels(NCH),
    .DataWidth(DW),
    .FifoDepth(DEPTH),
    .LfsrSeed(SEED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_i(enable),
    .mode_i(mode),
    .prob_i(prob),
    .period_i(period),
    .bus(bus),
    .fifo_full_o(fifo_full),
    .stall_cnt_o(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [DW-1:0] v);
    bus.data_i[c*DW +: DW] = v;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  initial begin
    logic [15:0] m;
    int g;
    int e;

    rst_n  = 1'b0;
    enable = 1'b1;
    mode   = 2'd0;
    prob   = 8'd0;
    period = 8'd0;
    bus.valid_i      = '0;
    bus.data_i       = '0;
    bus.word_ready_i = 1'b1;

    // reset state
    @(posedge clk);
    #1;
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_word_valid", bus.word_valid_o, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_stall", stall_cnt, 0);

    // mode 0, single channel, incrementing data
    do_reset();
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      set_data(0, k);
      bus.valid_i = 3'b001;
      #1;
      chk("m0_grant", bus.grant_o, 3'b001);
      if (k > 0) begin
        chk("m0_word_valid", bus.word_valid_o, 1);
        chk("m0_word", bus.word_o, k - 1);
      end
      chk("m0_stall", stall_cnt, 0);
      next_cycle();
    end
    bus.valid_i = '0;
    #1;
    chk("m0_last_word", bus.word_o, 5);
    chk("m0_last_chan", bus.word_chan_o, 0);
    chk("m0_stall_end", stall_cnt, 0);
    next_cycle();
    chk("m0_drained", bus.word_valid_o, 0);

    // mode 2, period 3: grant one cycle in four, stall +3 per grant
    mode   = 2'd2;
    period = 8'd3;
    bus.valid_i = 3'b001;
    set_data(0, 32'hB0);
    do_reset();
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("m2_grant", bus.grant_o, (i >= 4 && (i % 4) == 0) ? 1 : 0);
      chk("m2_stall", stall_cnt, (i == 0) ? 0 : i - (i - 1) / 4);
      next_cycle();
      #1;
    end

    // three channels round-robin, then only ch2
    mode   = 2'd0;
    period = 8'd0;
    bus.valid_i = '0;
    for (int c = 0; c < NCH; c++) set_data(c, 32'hC0 + c);
    do_reset();
    next_cycle();
    bus.valid_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_grant", bus.grant_o, 1 << (i % 3));
      if (i > 0) begin
        chk("rr_chan", bus.word_chan_o, (i - 1) % 3);
        chk("rr_word", bus.word_o, 32'hC0 + (i - 1) % 3);
      end
      next_cycle();
    end
    bus.valid_i = 3'b100;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("ch2_grant", bus.grant_o, 3'b100);
      chk("ch2_chan", bus.word_chan_o, 2);
      next_cycle();
    end

    // FIFO fill to full, single pop, refill, drain
    bus.valid_i      = '0;
    bus.word_ready_i = 1'b0;
    do_reset();
    next_cycle();
    bus.valid_i = 3'b001;
    for (int k = 0; k < 4; k++) begin
      set_data(0, 32'hD0 + k);
      #1;
      chk("fill_grant", bus.grant_o, 3'b001);
      chk("fill_not_full", fifo_full, 0);
      exp_q.push_back(32'hD0 + k);
      next_cycle();
    end
    set_data(0, 32'hD4);
    #1;
    chk("full_flag", fifo_full, 1);
    chk("full_no_grant", bus.grant_o, 0);
    chk("full_word_valid", bus.word_valid_o, 1);
    next_cycle();
    bus.word_ready_i = 1'b1;
    #1;
    chk("full_pop_no_grant", bus.grant_o, 0);
    chk("full_pop_flag", fifo_full, 1);
    chk("full_pop_word", bus.word_o, exp_q.pop_front());
    next_cycle();
    bus.word_ready_i = 1'b0;
    #1;
    chk("after_pop_full", fifo_full, 0);
    chk("after_pop_grant", bus.grant_o, 3'b001);
    exp_q.push_back(32'hD4);
    next_cycle();
    set_data(0, 32'hD5);
    #1;
    chk("refull_flag", fifo_full, 1);
    chk("refull_no_grant", bus.grant_o, 0);
    next_cycle();
    bus.valid_i      = '0;
    bus.word_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", bus.word_valid_o, 1);
      chk("drain_word", bus.word_o, exp_q.pop_front());
      next_cycle();
    end
    #1;
    chk("drain_empty", bus.word_valid_o, 0);

    // mode 3 hold-delay, period 2: grant every 3rd cycle of continuous valid
    mode   = 2'd3;
    period = 8'd2;
    bus.valid_i = '0;
    do_reset();
    next_cycle();
    bus.valid_i = 3'b001;
    for (int i = 1; i <= 9; i++) begin
      #1;
      chk("m3_grant", bus.grant_o, ((i % 3) == 0) ? 1 : 0);
      next_cycle();
    end

    // mode 1, prob 0: never grants
    mode = 2'd1;
    prob = 8'd0;
    bus.valid_i = 3'b001;
    do_reset();
    g = 0;
    for (int k = 0; k < 1000; k++) begin
      next_cycle();
      #1;
      if (bus.grant_o[0]) g++;
    end
    chk("m1_p0_count", g, 0);

    // mode 1, prob 128: count against LFSR model and expected range
    prob = 8'd128;
    do_reset();
    m = SEED;
    g = 0;
    e = 0;
    for (int k = 0; k < 1000; k++) begin
      next_cycle();
      #1;
      if (m[7:0] < prob) e++;
      m = lfsr_step(m);
      if (bus.grant_o[0]) g++;
    end
    chk("m1_p128_model", g, e);
    chk("m1_p128_range", (g >= 450 && g <= 550) ? 1 : 0, 1);

    // asynchronous reset mid-burst, then identical LFSR behaviour
    mode = 2'd0;
    bus.valid_i      = '0;
    bus.word_ready_i = 1'b0;
    do_reset();
    next_cycle();
    bus.valid_i = 3'b001;
    set_data(0, 32'hE0);
    #1;
    chk("mid_grant0", bus.grant_o, 3'b001);
    next_cycle();
    set_data(0, 32'hE1);
    #1;
    chk("mid_word_valid", bus.word_valid_o, 1);
    chk("mid_grant1", bus.grant_o, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("async_word_valid", bus.word_valid_o, 0);
    chk("async_grant", bus.grant_o, 0);
    chk("async_full", fifo_full, 0);
    chk("async_stall", stall_cnt, 0);
    mode = 2'd1;
    prob = 8'd128;
    bus.word_ready_i = 1'b1;
    do_reset();
    m = SEED;
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      #1;
      chk("rst_lfsr_grant", bus.grant_o[0], (m[7:0] < prob) ? 1 : 0);
      m = lfsr_step(m);
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
